// File: rtl/mem_seg.sv
// MEM pipeline stage: EX/MEM register plus word load/store handshake to data memory.
// Retires every accepted instruction to WB exactly once; idle edges retire a NOP bubble.
module mem_seg #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [5:0]  OP_LW       = 6'h23,
    parameter logic [5:0]  OP_SW       = 6'h2B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ALUo_i,
    input  logic [31:0] B_i,
    input  logic [31:0] IR_i,
    output logic        mem_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [31:0] LMD_o,
    output logic [31:0] ALUo_o,
    output logic [31:0] IR_o,
    output logic        wb_valid,
    output logic        mem_err
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_ir;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_we;
    logic [31:0]     r_lmd;
    logic [31:0]     r_aluo;
    logic [31:0]     r_ir_o;
    logic            r_wb_valid;
    logic            r_mem_err;

    logic [5:0] w_op;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_mem;
    logic       w_misaligned;
    logic       w_finish;

    assign w_op         = IR_i[31:26];
    assign w_is_lw      = (w_op == OP_LW);
    assign w_is_sw      = (w_op == OP_SW);
    assign w_is_mem     = w_is_lw | w_is_sw;
    assign w_misaligned = (ALUo_i[1:0] != 2'b00);
    // An ack on the final counted cycle still completes normally rather than timing out.
    assign w_finish     = dm_ack | (r_cnt == CntLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_ir       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_lmd      <= '0;
            r_aluo     <= '0;
            r_ir_o     <= '0;
            r_wb_valid <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            // Bubble unless a retire below overrides; LMD/ALUo hold.
            r_ir_o     <= '0;
            r_wb_valid <= 1'b0;
            r_mem_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (ex_valid) begin
                        r_ir    <= IR_i;
                        r_addr  <= ALUo_i;
                        r_wdata <= B_i;
                        r_we    <= w_is_sw;
                        if (w_is_mem && !w_misaligned) begin
                            r_state <= StAccess;
                            r_cnt   <= '0;
                        end else begin
                            r_ir_o     <= IR_i;
                            r_aluo     <= ALUo_i;
                            r_lmd      <= '0;
                            r_wb_valid <= 1'b1;
                            r_mem_err  <= w_is_mem;
                        end
                    end
                end
                StAccess: begin
                    if (w_finish) begin
                        r_ir_o     <= r_ir;
                        r_aluo     <= r_addr;
                        r_lmd      <= (dm_ack && !r_we) ? dm_rdata : 32'h0;
                        r_wb_valid <= 1'b1;
                        r_mem_err  <= ~dm_ack;
                        r_state    <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_stall = (r_state == StAccess);
    assign dm_req    = (r_state == StAccess);
    assign dm_we     = r_we;
    assign dm_addr   = r_addr;
    assign dm_wdata  = r_wdata;
    assign LMD_o     = r_lmd;
    assign ALUo_o    = r_aluo;
    assign IR_o      = r_ir_o;
    assign wb_valid  = r_wb_valid;
    assign mem_err   = r_mem_err;

endmodule
